// File: rtl/mux_arbiter_if.sv
// Bundle of request, data and grant signals shared between requesters and
// the round-robin mux arbiter.
interface mux_arbiter_if;
   logic [3:0] req;
   logic [3:0] data_in;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       valid;
   logic       f;
   logic [3:0] disp;

   modport master (
      output req, data_in,
      input  grant, sel, valid, f, disp
   );

   modport slave (
      input  req, data_in,
      output grant, sel, valid, f, disp
   );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a hold timeout, one-cycle
// turnaround bubble between owners, forwarded data bit and display code.
module mux_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   mux_arbiter_if.slave   bus
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [0:0] state_q,    state_d;
   logic [3:0] grant_q,    grant_d;
   logic [1:0] sel_q,      sel_d;
   logic       valid_q,    valid_d;
   logic [1:0] last_q,     last_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;

   logic [1:0] cand [4];
   logic [1:0] winner;
   logic       any_req;
   logic       others_waiting;
   logic       owner_release;
   logic       owner_timeout;

   // Search order starts just after the last owner and ends on it; the 2-bit
   // add wraps 3+1 to 0.
   for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_q + 2'(gi + 1);
   end

   always_comb begin
      winner = last_q;
      for (int i = 3; i >= 0; i--) begin
         if (bus.req[cand[i]]) begin
            winner = cand[i];
         end
      end
   end

   assign any_req        = |bus.req;
   assign others_waiting = |(bus.req & ~(4'b0001 << sel_q));
   assign owner_release  = ~bus.req[sel_q];
   assign owner_timeout  = (hold_cnt_q == HOLD_MAX) && others_waiting;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      valid_d    = valid_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            grant_d = 4'b0000;
            valid_d = 1'b0;
            if (any_req) begin
               state_d    = ST_GRANT;
               sel_d      = winner;
               grant_d    = 4'b0001 << winner;
               valid_d    = 1'b1;
               hold_cnt_d = 8'd1;
            end
         end
         default: begin
            // Release and timeout lead to the same bubble, so one branch covers both.
            if (owner_release || owner_timeout) begin
               state_d    = ST_IDLE;
               grant_d    = 4'b0000;
               valid_d    = 1'b0;
               last_d     = sel_q;
               hold_cnt_d = 8'd0;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'b00;
         valid_q    <= 1'b0;
         last_q     <= 2'd3;
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.valid = valid_q;
   assign bus.f     = valid_q & bus.data_in[sel_q];
   assign bus.disp  = valid_q ? {2'b00, sel_q} : 4'b1111;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and randomized checks of mux_arbiter against an owner/tenure
// reference model of the round-robin rules.
module tb_mux_arbiter;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic reset_n;
   mux_arbiter_if bus ();

   mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the mux, for how long, and who owned it last.
   int m_owner;
   int m_last;
   int m_sel;
   int m_tenure;

   task automatic model_edge();
      bit others;
      if (!reset_n) begin
         m_owner = -1; m_last = 3; m_sel = 0; m_tenure = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (bus.req[c]) begin
               m_owner = c; m_sel = c; m_tenure = 1;
               break;
            end
         end
      end else begin
         others = 1'b0;
         for (int j = 0; j < 4; j++)
            if (j != m_owner && bus.req[j]) others = 1'b1;
         if (!bus.req[m_owner] || (m_tenure >= MAX_HOLD && others)) begin
            m_last = m_owner; m_owner = -1;
         end else if (m_tenure < MAX_HOLD) begin
            m_tenure++;
         end
      end
   endtask

   task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] e_grant, e_disp;
      logic [1:0] e_sel;
      logic       e_valid, e_f;
      e_valid = (m_owner >= 0);
      e_sel   = 2'(m_sel);
      e_grant = e_valid ? (4'b0001 << e_sel) : 4'b0000;
      e_f     = e_valid ? bus.data_in[e_sel] : 1'b0;
      e_disp  = e_valid ? {2'b00, e_sel} : 4'b1111;
      expect4({tag, ".grant"}, bus.grant, e_grant);
      expect4({tag, ".sel"}, {2'b00, bus.sel}, {2'b00, e_sel});
      expect4({tag, ".valid"}, {3'b000, bus.valid}, {3'b000, e_valid});
      expect4({tag, ".f"}, {3'b000, bus.f}, {3'b000, e_f});
      expect4({tag, ".disp"}, bus.disp, e_disp);
      $display("[%0t] %s rst_n=%b req=%b data=%b -> grant=%b sel=%0d valid=%b f=%b disp=%b",
               $time, tag, reset_n, bus.req, bus.data_in, bus.grant, bus.sel,
               bus.valid, bus.f, bus.disp);
   endtask

   task automatic cycle(input logic rn, input logic [3:0] r, input logic [3:0] d,
                        input string tag);
      reset_n     = rn;
      bus.req     = r;
      bus.data_in = d;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   logic [3:0] hist [64];
   logic [3:0] prev_g;
   logic [3:0] req_r;
   int         entries;

   initial begin
      reset_n = 1'b0; bus.req = 4'b0000; bus.data_in = 4'b0000;
      m_owner = -1; m_last = 3; m_sel = 0; m_tenure = 0;

      // 1: reset with everyone requesting, then first grant goes to 0
      cycle(1'b0, 4'b1111, 4'b1111, "t1_rst");
      cycle(1'b0, 4'b1111, 4'b1111, "t1_rst");
      expect4("t1_rst_grant", bus.grant, 4'b0000);
      expect4("t1_rst_disp", bus.disp, 4'b1111);
      expect4("t1_rst_f", {3'b000, bus.f}, 4'b0000);
      cycle(1'b1, 4'b1111, 4'b1111, "t1_first");
      expect4("t1_first_grant", bus.grant, 4'b0001);
      expect4("t1_first_disp", bus.disp, 4'b0000);

      // 2: lone requester keeps grant indefinitely
      cycle(1'b0, 4'b0000, 4'b0000, "t2_rst");
      cycle(1'b1, 4'b0100, 4'b0100, "t2_grant");
      expect4("t2_grant", bus.grant, 4'b0100);
      expect4("t2_f", {3'b000, bus.f}, 4'b0001);
      expect4("t2_disp", bus.disp, 4'b0010);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 4'b0100, 4'b0100, "t2_hold");
         expect4("t2_hold_grant", bus.grant, 4'b0100);
      end
      cycle(1'b1, 4'b0000, 4'b0100, "t2_drop");
      expect4("t2_drop_valid", {3'b000, bus.valid}, 4'b0000);

      // 3: two-way contention alternates in MAX_HOLD windows with a bubble
      cycle(1'b0, 4'b0000, 4'b0000, "t3_rst");
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 4'b0011, 4'(i), "t3_cont");
         hist[i] = bus.grant;
      end
      for (int i = 0; i < 8; i++) expect4("t3_own0", hist[i], 4'b0001);
      expect4("t3_bubble0", hist[8], 4'b0000);
      for (int i = 9; i < 17; i++) expect4("t3_own1", hist[i], 4'b0010);
      expect4("t3_bubble1", hist[17], 4'b0000);
      expect4("t3_again0", hist[18], 4'b0001);

      // 4: full rotation with constant requests
      cycle(1'b0, 4'b0000, 4'b0000, "t4_rst");
      prev_g = 4'b0000; entries = 0;
      for (int i = 0; i < 45; i++) begin
         cycle(1'b1, 4'b1111, 4'(i * 3), "t4_rot");
         if (bus.grant != 4'b0000 && prev_g == 4'b0000) begin
            expect4("t4_order", bus.grant, 4'b0001 << (entries % 4));
            entries++;
         end
         if (bus.grant != 4'b0000 && prev_g != 4'b0000)
            expect4("t4_no_direct_switch", bus.grant, prev_g);
         prev_g = bus.grant;
      end
      expect4("t4_entries", 4'(entries), 4'd5);

      // 5: early release by requester 3 wraps to requester 0
      cycle(1'b0, 4'b0000, 4'b0000, "t5_rst");
      cycle(1'b1, 4'b1000, 4'b1000, "t5_own3");
      expect4("t5_disp3", bus.disp, 4'b0011);
      cycle(1'b1, 4'b1001, 4'b1000, "t5_hold");
      cycle(1'b1, 4'b0001, 4'b1001, "t5_drop");
      expect4("t5_bubble", bus.disp, 4'b1111);
      cycle(1'b1, 4'b0001, 4'b1001, "t5_wrap");
      expect4("t5_wrap_grant", bus.grant, 4'b0001);
      expect4("t5_wrap_disp", bus.disp, 4'b0000);

      // 6: reset mid-grant, then a fresh full window for requester 2
      cycle(1'b0, 4'b0000, 4'b0000, "t6_rst");
      cycle(1'b1, 4'b0100, 4'b0100, "t6_grant");
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'b1100, 4'b0100, "t6_hold");
      cycle(1'b0, 4'b0100, 4'b0100, "t6_midrst");
      expect4("t6_midrst_grant", bus.grant, 4'b0000);
      expect4("t6_midrst_disp", bus.disp, 4'b1111);
      cycle(1'b1, 4'b0100, 4'b0100, "t6_regrant");
      expect4("t6_regrant", bus.grant, 4'b0100);
      entries = 1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 4'b1100, 4'b0100, "t6_window");
         if (bus.grant == 4'b0100) entries++;
      end
      expect4("t6_window_len", 4'(entries), 4'(MAX_HOLD));

      // Random phase: sticky random requests, random data, occasional reset
      req_r = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req_r[$urandom_range(0, 3)] ^= 1'b1;
         cycle(($urandom_range(0, 99) != 0), req_r, 4'($urandom), "rnd");
         bus.data_in = 4'($urandom);
         #1;
         expect4("rnd_f_comb", {3'b000, bus.f},
                 {3'b000, (m_owner >= 0) ? bus.data_in[2'(m_sel)] : 1'b0});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "simulation time limit reached");
   end

endmodule
